// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Shares the single register-file write port between three write-back requesters:
//   0 = ALU result (rd), 1 = load data (rt), 2 = link/$31 (jal).
//   Each requester owns a one-entry holding buffer. A round-robin arbiter drains one
//   buffered entry per cycle onto registered regfile write outputs.
//
// Optional feature macro: WB_ARB_ZERO_FILTER_EN
//   Defined:   an entry addressed to $zero is granted and consumed normally (wb_sel and
//              wb_addr update) but o_wb_we stays 0 for that write.
//   Undefined: $zero entries write like any other; the regfile discards them itself.
//
// Parameters
//   DW  write-back data width
//   AW  register address width
//
// Ports
//   i_clk                 system clock, all state on posedge
//   i_rst                 synchronous reset, active-high
//   i_reqN/i_addrN/i_dataN  requester N write request, destination, data (N = 0..2)
//   o_rdyN                requester N may issue; accepted when i_reqN & o_rdyN
//   o_wb_we               regfile write enable (registered)
//   o_wb_sel              dest-select code 00/01/10 = requester 0/1/2, 11 = idle (registered)
//   o_wb_addr             regfile write address (registered)
//   o_wb_data             regfile write data (registered)
//   o_busy                any holding buffer occupied

module wb_port_arbiter #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_req0,
  input  logic [AW-1:0] i_addr0,
  input  logic [DW-1:0] i_data0,
  output logic          o_rdy0,
  input  logic          i_req1,
  input  logic [AW-1:0] i_addr1,
  input  logic [DW-1:0] i_data1,
  output logic          o_rdy1,
  input  logic          i_req2,
  input  logic [AW-1:0] i_addr2,
  input  logic [DW-1:0] i_data2,
  output logic          o_rdy2,
  output logic          o_wb_we,
  output logic [1:0]    o_wb_sel,
  output logic [AW-1:0] o_wb_addr,
  output logic [DW-1:0] o_wb_data,
  output logic          o_busy
);

  localparam logic [1:0] SelIdle = 2'b11;

  logic [2:0]          r_pend;
  logic [2:0][AW-1:0]  r_addr;
  logic [2:0][DW-1:0]  r_data;
  logic [1:0]          r_last;
  logic                r_wb_we;
  logic [1:0]          r_wb_sel;
  logic [AW-1:0]       r_wb_addr;
  logic [DW-1:0]       r_wb_data;

  logic [2:0]          w_req;
  logic [2:0][AW-1:0]  w_addr_in;
  logic [2:0][DW-1:0]  w_data_in;
  logic [2:0]          w_gnt;
  logic [1:0]          w_gnt_idx;
  logic [2:0]          w_rdy;
  logic [2:0]          w_acc;
  logic [2:0]          w_pend_d;
  logic                w_we_d;

  assign w_req     = {i_req2, i_req1, i_req0};
  assign w_addr_in = {i_addr2, i_addr1, i_addr0};
  assign w_data_in = {i_data2, i_data1, i_data0};

  // Round-robin: scan starting just after the last granted index.
  always_comb begin
    w_gnt = 3'b000;
    case (r_last)
      2'd0: begin
        if (r_pend[1])      w_gnt = 3'b010;
        else if (r_pend[2]) w_gnt = 3'b100;
        else if (r_pend[0]) w_gnt = 3'b001;
      end
      2'd1: begin
        if (r_pend[2])      w_gnt = 3'b100;
        else if (r_pend[0]) w_gnt = 3'b001;
        else if (r_pend[1]) w_gnt = 3'b010;
      end
      default: begin
        if (r_pend[0])      w_gnt = 3'b001;
        else if (r_pend[1]) w_gnt = 3'b010;
        else if (r_pend[2]) w_gnt = 3'b100;
      end
    endcase
  end

  always_comb begin
    w_gnt_idx = 2'd0;
    unique case (w_gnt)
      3'b010:  w_gnt_idx = 2'd1;
      3'b100:  w_gnt_idx = 2'd2;
      default: w_gnt_idx = 2'd0;
    endcase
  end

  // A draining entry frees its slot in the same cycle, so a refill can land on it.
  assign w_rdy    = ~r_pend | w_gnt;
  assign w_acc    = w_req & w_rdy;
  assign w_pend_d = w_acc | (r_pend & ~w_gnt);

`ifdef WB_ARB_ZERO_FILTER_EN
  assign w_we_d = (r_addr[w_gnt_idx] != '0);
`else
  assign w_we_d = 1'b1;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pend    <= 3'b000;
      r_addr    <= '0;
      r_data    <= '0;
      r_last    <= 2'd2;
      r_wb_we   <= 1'b0;
      r_wb_sel  <= SelIdle;
      r_wb_addr <= '0;
      r_wb_data <= '0;
    end else begin
      r_pend <= w_pend_d;
      for (int i = 0; i < 3; i++) begin
        if (w_acc[i]) begin
          r_addr[i] <= w_addr_in[i];
          r_data[i] <= w_data_in[i];
        end
      end
      if (|w_gnt) begin
        r_last    <= w_gnt_idx;
        r_wb_we   <= w_we_d;
        r_wb_sel  <= w_gnt_idx;
        r_wb_addr <= r_addr[w_gnt_idx];
        r_wb_data <= r_data[w_gnt_idx];
      end else begin
        r_wb_we  <= 1'b0;
        r_wb_sel <= SelIdle;
      end
    end
  end

  assign o_rdy0    = w_rdy[0];
  assign o_rdy1    = w_rdy[1];
  assign o_rdy2    = w_rdy[2];
  assign o_wb_we   = r_wb_we;
  assign o_wb_sel  = r_wb_sel;
  assign o_wb_addr = r_wb_addr;
  assign o_wb_data = r_wb_data;
  assign o_busy    = |r_pend;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter
//   Directed scenarios followed by randomized traffic, all checked against a
//   transaction-level reference model of the three holding slots and the round-robin pointer.

module tb_wb_port_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk;
  logic          rst;
  logic          req [3];
  logic [AW-1:0] addr [3];
  logic [DW-1:0] data [3];
  logic          rdy0, rdy1, rdy2;
  logic          wb_we;
  logic [1:0]    wb_sel;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          busy;

  wb_port_arbiter #(.DW(DW), .AW(AW)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_req0   (req[0]),
    .i_addr0  (addr[0]),
    .i_data0  (data[0]),
    .o_rdy0   (rdy0),
    .i_req1   (req[1]),
    .i_addr1  (addr[1]),
    .i_data1  (data[1]),
    .o_rdy1   (rdy1),
    .i_req2   (req[2]),
    .i_addr2  (addr[2]),
    .i_data2  (data[2]),
    .o_rdy2   (rdy2),
    .o_wb_we  (wb_we),
    .o_wb_sel (wb_sel),
    .o_wb_addr(wb_addr),
    .o_wb_data(wb_data),
    .o_busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: each slot is either empty or holds one (addr, data) write.
  bit            m_known = 0;
  bit            m_valid [3];
  logic [AW-1:0] m_addr [3];
  logic [DW-1:0] m_data [3];
  int            m_last;
  bit            e_we;
  logic [1:0]    e_sel;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;
  bit            m_acc [3];

  // One clock: inputs already driven; returns just after the following negedge.
  task automatic tick();
    int  g;
    bit  mr [3];
    logic [2:0] rdy_v;
    g = -1;
    for (int k = 1; k <= 3; k++) begin
      int j;
      j = (m_last + k) % 3;
      if (g < 0 && m_valid[j]) g = j;
    end
    for (int i = 0; i < 3; i++) mr[i] = !m_valid[i] || (g == i);
    if (m_known) begin
      rdy_v = {rdy2, rdy1, rdy0};
      check_eq("rdy", {61'd0, rdy_v}, {61'd0, mr[2], mr[1], mr[0]});
      check_eq("busy", {63'd0, busy},
               {63'd0, (m_valid[0] || m_valid[1] || m_valid[2])});
    end
    for (int i = 0; i < 3; i++) m_acc[i] = !rst && req[i] && mr[i];
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        m_valid[i] = 0;
        m_addr[i]  = '0;
        m_data[i]  = '0;
      end
      m_last  = 2;
      e_we    = 0;
      e_sel   = 2'b11;
      e_addr  = '0;
      e_data  = '0;
      m_known = 1;
    end else begin
      if (g >= 0) begin
`ifdef WB_ARB_ZERO_FILTER_EN
        e_we = (m_addr[g] != 0);
`else
        e_we = 1;
`endif
        e_sel      = 2'(g);
        e_addr     = m_addr[g];
        e_data     = m_data[g];
        m_valid[g] = 0;
        m_last     = g;
      end else begin
        e_we  = 0;
        e_sel = 2'b11;
      end
      for (int i = 0; i < 3; i++) begin
        if (m_acc[i]) begin
          m_valid[i] = 1;
          m_addr[i]  = addr[i];
          m_data[i]  = data[i];
        end
      end
    end
    @(negedge clk);
    if (m_known) begin
      check_eq("wb_we", {63'd0, wb_we}, {63'd0, e_we});
      check_eq("wb_sel", {62'd0, wb_sel}, {62'd0, e_sel});
      check_eq("wb_addr", {59'd0, wb_addr}, {59'd0, e_addr});
      check_eq("wb_data", {32'd0, wb_data}, {32'd0, e_data});
    end
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < 3; i++) begin
      req[i]  = 0;
      addr[i] = '0;
      data[i] = '0;
    end
  endtask

  initial begin
    bit hold [3];
    idle_inputs();
    rst = 1;

    // Reset held two cycles.
    tick();
    tick();
    rst = 0;
    check_eq("rst_we", {63'd0, wb_we}, 64'd0);
    check_eq("rst_sel", {62'd0, wb_sel}, 64'd3);
    check_eq("rst_rdy", {61'd0, rdy2, rdy1, rdy0}, 64'd7);
    check_eq("rst_busy", {63'd0, busy}, 64'd0);

    // Single write from requester 1.
    req[1] = 1; addr[1] = 5'd9; data[1] = 32'hDEADBEEF;
    tick();
    idle_inputs();
    check_eq("single_busy", {63'd0, busy}, 64'd1);
    tick();
    check_eq("single_we", {63'd0, wb_we}, 64'd1);
    check_eq("single_sel", {62'd0, wb_sel}, 64'd1);
    check_eq("single_addr", {59'd0, wb_addr}, 64'd9);
    check_eq("single_data", {32'd0, wb_data}, 64'hDEADBEEF);
    tick();
    check_eq("single_idle", {62'd0, wb_sel}, 64'd3);

    // All three at once after reset: drain 0,1,2.
    rst = 1; tick(); rst = 0;
    for (int i = 0; i < 3; i++) begin
      req[i] = 1; addr[i] = 5'(i + 1); data[i] = 32'(100 + i);
    end
    tick();
    idle_inputs();
    check_eq("all_rdy", {61'd0, rdy2, rdy1, rdy0}, 64'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("all_order", {62'd0, wb_sel}, 64'(k));
    end
    tick();

    // Back-to-back on requester 0 with data 1,2,3.
    for (int k = 1; k <= 3; k++) begin
      req[0] = 1; addr[0] = 5'd4; data[0] = 32'(k);
      if (k > 1) check_eq("b2b_rdy0", {63'd0, rdy0}, 64'd1);
      tick();
      if (k > 1) check_eq("b2b_data", {32'd0, wb_data}, 64'(k - 1));
    end
    idle_inputs();
    tick();
    check_eq("b2b_last", {32'd0, wb_data}, 64'd3);
    tick();

    // Reset while all three slots are full.
    for (int i = 0; i < 3; i++) begin
      req[i] = 1; addr[i] = 5'(7 + i); data[i] = 32'(200 + i);
    end
    tick();
    idle_inputs();
    rst = 1; tick(); rst = 0;
    tick();
    check_eq("midrst_we", {63'd0, wb_we}, 64'd0);
    check_eq("midrst_busy", {63'd0, busy}, 64'd0);
    req[1] = 1; req[0] = 1; addr[0] = 5'd3; addr[1] = 5'd3;
    tick();
    idle_inputs();
    tick();
    check_eq("midrst_first", {62'd0, wb_sel}, 64'd0);
    tick();
    tick();

    // Write to $zero from requester 2.
    req[2] = 1; addr[2] = '0; data[2] = 32'h5;
    tick();
    idle_inputs();
    tick();
    check_eq("zero_sel", {62'd0, wb_sel}, 64'd2);
    check_eq("zero_addr", {59'd0, wb_addr}, 64'd0);
`ifdef WB_ARB_ZERO_FILTER_EN
    check_eq("zero_we", {63'd0, wb_we}, 64'd0);
`else
    check_eq("zero_we", {63'd0, wb_we}, 64'd1);
`endif
    tick();

    // Random traffic; a refused requester holds its request and payload.
    for (int i = 0; i < 3; i++) hold[i] = 0;
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      for (int i = 0; i < 3; i++) begin
        if (!hold[i]) begin
          req[i]  = ($urandom_range(0, 99) < 55);
          addr[i] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
          data[i] = $urandom;
        end
      end
      tick();
      for (int i = 0; i < 3; i++) hold[i] = !rst && req[i] && !m_acc[i];
    end
    rst = 0;
    idle_inputs();
    for (int c = 0; c < 4; c++) tick();
    check_eq("drain_busy", {63'd0, busy}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
